// File: rtl/sipo_absorb_ctrl_pkg.sv
// sipo_absorb_ctrl_pkg: shared Keccak absorb constants and the sequencer state type
package sipo_absorb_ctrl_pkg;
  localparam int SHAKE128_RATE = 1344;
  localparam int SHAKE256_RATE = 1088;
  localparam int WORD_W = 64;
  localparam logic [7:0] DOM_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END = 8'h80;
  typedef enum logic [1:0] {FILL, PAD, FULL} state_t;
endpackage

// File: rtl/sipo_absorb_ctrl_sipo.sv
// sipo_absorb_ctrl_sipo: n-bit shift-in register, m bits per shift, first word ends at q[m-1:0]
// ports: clk, en (shift enable), din (word in), q (register contents)
module sipo_absorb_ctrl_sipo #(
  parameter int n = 1344,
  parameter int m = 64
) (
  input  logic         clk,
  input  logic         en,
  input  logic [m-1:0] din,
  output logic [n-1:0] q
);
  always_ff @(posedge clk)
    if (en) q <= {din, q[n-1:m]};
endmodule

// File: rtl/sipo_absorb_ctrl.sv
// sipo_absorb_ctrl: SHAKE padding sequencer feeding the rate SIPO and handing blocks to the core
// ports: clk, rst_n; in_* word stream (valid/ready, last, byte count);
//        sipo_en/sipo_data shift interface; blk_valid/blk_last/blk_ready block handshake;
//        blk_data SIPO contents; busy while a message or its padding is in flight
module sipo_absorb_ctrl
  import sipo_absorb_ctrl_pkg::*;
#(
  parameter int N = SHAKE128_RATE,
  parameter int M = WORD_W,
  parameter logic [7:0] DOM = DOM_SHAKE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [3:0]   in_bytes,
  output logic         in_ready,
  output logic         sipo_en,
  output logic [M-1:0] sipo_data,
  output logic         blk_valid,
  output logic         blk_last,
  input  logic         blk_ready,
  output logic         busy,
  output logic [N-1:0] blk_data
);
  localparam int WORDS = N / M;
  localparam int B = M / 8;
  localparam int CW = $clog2(WORDS);
  state_t state;
  logic [CW-1:0] cnt;
  logic dom_pend, last_q;
  logic top, acc, short_last;
  logic [3:0] k;
  logic [M-1:0] keep, end_bit, last_word, pad_word;
  assign top = cnt == CW'(WORDS - 1);
  assign k = in_bytes > 4'(B) ? 4'(B) : in_bytes;
  assign short_last = in_last && k < 4'(B);
  assign keep = (M'(1) << {k, 3'b0}) - M'(1);
  assign end_bit = M'(PAD_END) << (M - 8);
  // the final rate byte gets 0x80 even when it also carries the domain byte
  assign last_word = (in_data & keep) | (M'(DOM) << {k, 3'b0}) | (top ? end_bit : '0);
  assign pad_word = (dom_pend ? M'(DOM) : '0) | (top ? end_bit : '0);
  assign in_ready = state == FILL;
  assign acc = in_ready && in_valid;
  assign sipo_en = acc || state == PAD;
  assign sipo_data = state == PAD ? pad_word : !acc ? '0 : short_last ? last_word : in_data;
  assign blk_valid = state == FULL;
  assign blk_last = blk_valid && last_q;
  assign busy = state != FILL || cnt != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FILL;
      cnt <= '0;
      dom_pend <= 1'b0;
      last_q <= 1'b0;
    end else
      case (state)
        FILL:
          if (acc) begin
            cnt <= top ? cnt : cnt + CW'(1);
            // a full last word leaves the domain byte for a following pad word
            dom_pend <= in_last && !short_last;
            last_q <= top && short_last;
            state <= top ? FULL : in_last ? PAD : FILL;
          end
        PAD: begin
          cnt <= top ? cnt : cnt + CW'(1);
          dom_pend <= 1'b0;
          last_q <= top;
          state <= top ? FULL : PAD;
        end
        FULL:
          if (blk_ready) begin
            cnt <= '0;
            last_q <= 1'b0;
            state <= last_q ? FILL : dom_pend ? PAD : FILL;
          end
        default: state <= FILL;
      endcase
  sipo_absorb_ctrl_sipo #(.n(N), .m(M)) u_sipo (
    .clk(clk),
    .en(sipo_en),
    .din(sipo_data),
    .q(blk_data)
  );
endmodule
